// File: rtl/hazard_forward_unit.sv
// Forwarding-select and load-use stall unit: tracks in-flight destinations from EX
// onward and resolves each ID source operand against them, youngest producer first.
module hazard_forward_unit #(
  parameter int REG_AW    = 5,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_RDY  = 2,
  parameter int CNT_W     = 16,
  localparam int SEL_W    = $clog2(FWD_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]  id_src,
  input  logic [NUM_SRC-1:0]         id_src_used,
  input  logic [REG_AW-1:0]          id_rd,
  input  logic                       id_regwrite,
  input  logic                       id_is_load,
  input  logic                       flush,
  output logic                       stall_id,
  output logic [NUM_SRC*SEL_W-1:0]   ex_fwd_sel,
  output logic [CNT_W-1:0]           stall_cnt
);

  logic [FWD_DEPTH:0]         v_q, v_d;
  logic [FWD_DEPTH:0]         we_q, we_d;
  logic [FWD_DEPTH:0]         ld_q, ld_d;
  logic [REG_AW-1:0]          rd_q [0:FWD_DEPTH];
  logic [REG_AW-1:0]          rd_d [0:FWD_DEPTH];
  logic [NUM_SRC*SEL_W-1:0]   ex_fwd_sel_q, ex_fwd_sel_d;
  logic [CNT_W-1:0]           stall_cnt_q, stall_cnt_d;

  logic [NUM_SRC*SEL_W-1:0]   cand_sel_s;
  logic [NUM_SRC-1:0]         hazard_s;
  logic [REG_AW-1:0]          src_s;
  logic                       found_s;
  logic                       stall_s;
  logic                       enter_s;

  // Operand resolution: S[FWD_DEPTH] is excluded because the regfile write lands before the read.
  always_comb begin
    cand_sel_s = '0;
    hazard_s   = '0;
    src_s      = '0;
    found_s    = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_s   = id_src[i*REG_AW +: REG_AW];
      found_s = 1'b0;
      for (int k = 0; k < FWD_DEPTH; k++) begin
        if (!found_s && v_q[k] && we_q[k] && (rd_q[k] == src_s) &&
            (src_s != '0) && id_src_used[i]) begin
          found_s                         = 1'b1;
          cand_sel_s[i*SEL_W +: SEL_W]    = SEL_W'(k + 1);
          hazard_s[i]                     = ld_q[k] && ((k + 1) < LOAD_RDY);
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  assign stall_s = id_valid && !flush && (|hazard_s);
  assign enter_s = id_valid && !stall_s && !flush;

  // Next tracker state, EX selects and saturating stall count.
  always_comb begin
    v_d[0]  = enter_s;
    we_d[0] = enter_s && id_regwrite;
    ld_d[0] = enter_s && id_is_load;
    if (enter_s) begin
      rd_d[0]      = id_rd;
      ex_fwd_sel_d = cand_sel_s;
    end else begin
      rd_d[0]      = '0;
      ex_fwd_sel_d = '0;
    end
    for (int k = 1; k <= FWD_DEPTH; k++) begin
      v_d[k]  = v_q[k-1];
      we_d[k] = we_q[k-1];
      ld_d[k] = ld_q[k-1];
      rd_d[k] = rd_q[k-1];
    end
    if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q          <= '0;
      we_q         <= '0;
      ld_q         <= '0;
      ex_fwd_sel_q <= '0;
      stall_cnt_q  <= '0;
      for (int k = 0; k <= FWD_DEPTH; k++) begin
        rd_q[k] <= '0;
      end
    end else begin
      v_q          <= v_d;
      we_q         <= we_d;
      ld_q         <= ld_d;
      ex_fwd_sel_q <= ex_fwd_sel_d;
      stall_cnt_q  <= stall_cnt_d;
      for (int k = 0; k <= FWD_DEPTH; k++) begin
        rd_q[k] <= rd_d[k];
      end
    end
  end

  assign stall_id   = stall_s;
  assign ex_fwd_sel = ex_fwd_sel_q;
  assign stall_cnt  = stall_cnt_q;

endmodule
